modbus_tx_sequencer: RTL and testbench
======================================

// Module: modbus_tx_sequencer
// PURPOSE
// - Sequences the Modbus RTU response after the function handler finishes; sole reader of the response DPRAM.
// - On handler_done, builds the reply frame: header, DPRAM payload or write echo, CRC-16.
// - Streams the frame bytewise to the UART transmitter, then enforces the inter-frame gap.
// PARAMETERS
// - MAX_WORDS   125   max tx_quantity accepted for 03/04; larger values produce exception 03
// - GAP_CYCLES  1750  idle clk cycles after last byte before busy drops (t3.5)
// PORTS
// - clk             in   1   system clock
// - rst_n           in   1   reset, asynchronous, active-low
// - dev_addr        in   8   slave address, first byte of every frame
// - handler_done    in   1   1-cycle pulse: response context valid this cycle
// - func_code       in   8   request function code; sampled on handler_done
// - addr            in   16  request start address; sampled on handler_done
// - data            in   16  request data/quantity; sampled on handler_done
// - tx_quantity     in   8   payload words in DPRAM; sampled on handler_done
// - exception_code  in   8   0 = normal, else Modbus exception code; sampled on handler_done
// - dpram_raddr     out  8   DPRAM read address
// - dpram_rdata     in   16  DPRAM read data, valid 1 cycle after dpram_raddr
// - tx_valid        out  1   byte valid toward UART
// - tx_byte         out  8   byte to transmit
// - tx_ready        in   1   UART accepts byte when tx_valid & tx_ready
// - busy            out  1   frame or gap in progress
// - frame_done      out  1   1-cycle pulse when gap ends
// - overrun         out  1   sticky: handler_done seen while busy; cleared by reset only
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; CRC register 16'hFFFF.
// - IDLE + handler_done: latch all inputs; busy=1 next cycle; CRC=FFFF.
// - Frame type (priority order):
//   - exception_code!=0                    -> EXC
//   - func 03/04 and tx_quantity>MAX_WORDS -> EXC, code 03
//   - func 03/04                           -> READ
//   - func 06                              -> ECHO
//   - any other func                       -> EXC, code 01
// - Byte sequences:
//   - EXC:  dev_addr, func|8'h80, code, CRClo, CRChi
//   - READ: dev_addr, func, 2*N (8-bit, N=tx_quantity), word0 hi, word0 lo, ..., CRClo, CRChi
//   - ECHO: dev_addr, 06, addr hi, addr lo, data hi, data lo, CRClo, CRChi
// - States: IDLE, HDR, RD_ISSUE, RD_WAIT, DATA_HI, DATA_LO, BODY, CRC_LO, CRC_HI, GAP.
// - READ payload:
//   - Word i: drive dpram_raddr=i in RD_ISSUE; capture dpram_rdata at end of RD_WAIT; send hi then lo.
//   - Next read is issued only after lo byte is accepted. N=0 -> byte count 0, straight to CRC.
// - Handshake:
//   - tx_byte stable while tx_valid & !tx_ready; tx_valid never drops without a transfer.
//   - Back-to-back bytes allowed within header/body.
// - CRC: Modbus (reflected poly 16'hA001, init FFFF); byte folded in on the transfer cycle only.
//   CRC bytes are not folded; low byte sent first.
// - GAP:
//   - Starts the cycle after the CRChi transfer; counts GAP_CYCLES cycles, tx_valid=0.
//   - Then frame_done pulses 1 cycle; busy=0 in the same cycle.
// - handler_done while busy: ignored (no relatch), overrun<=1.
// - Reset mid-frame: immediate return to IDLE, tx_valid=0, no partial CRC emitted.
// TESTING
// - Zero data read: dev 01, func 03, N=1, DPRAM[0]=0000, tx_ready=1 -> 01 03 02 00 00 B8 44; frame_done after GAP.
// - Exception: dev 01, exception_code 02, func 03 -> 01 83 02 C0 F1; no DPRAM reads.
// - Write echo: dev 01, func 06, addr 0001, data 0003 -> 01 06 00 01 00 03 98 0B.
// - Backpressure: func 04, N=4, tx_ready random 30% -> bytes/CRC unchanged vs tx_ready=1; tx_byte stable while stalled.
// - Bounds: N=126 on 03 -> exception 03 frame; func 10 -> exception 01 frame; handler_done while busy -> overrun=1, frame intact.
// - Reset mid-payload: rst_n low during DATA_LO -> tx_valid=0, busy=0; next request produces a correct full frame.

Source files
------------

// File: rtl/modbus_tx_sequencer_if.sv
// Byte stream toward the UART transmitter plus the read port of the response DPRAM.
// The sequencer is the master of both: it drives addresses and bytes, and the
// slave side returns read data and the UART ready.
interface modbus_tx_sequencer_if;
    logic [7:0]  dpram_raddr;
    logic [15:0] dpram_rdata;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;

    modport master (
        output dpram_raddr,
        output tx_valid,
        output tx_byte,
        input  dpram_rdata,
        input  tx_ready
    );

    modport slave (
        input  dpram_raddr,
        input  tx_valid,
        input  tx_byte,
        output dpram_rdata,
        output tx_ready
    );
endinterface

// File: rtl/modbus_tx_sequencer.sv
// Modbus RTU response sequencer: on handler_done, latches the response context,
// streams header / payload (DPRAM words or write echo) / CRC-16 bytewise to the
// UART, then holds busy for the t3.5 inter-frame gap.
module modbus_tx_sequencer #(
    parameter int MAX_WORDS  = 125,
    parameter int GAP_CYCLES = 1750
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             dev_addr,
    input  logic                   handler_done,
    input  logic [7:0]             func_code,
    input  logic [15:0]            addr,
    input  logic [15:0]            data,
    input  logic [7:0]             tx_quantity,
    input  logic [7:0]             exception_code,
    modbus_tx_sequencer_if.master  bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]    MAX_Q    = 8'(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE, HDR, RD_ISSUE, RD_WAIT, DATA_HI, DATA_LO, BODY, CRC_LO, CRC_HI, GAP
    } state_t;

    typedef enum logic [1:0] {K_EXC, K_READ, K_ECHO} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_in, kind_q;
    logic [7:0]    code_in, code_q;
    logic [7:0]    dev_q, func_q, n_q, word_idx_q;
    logic [15:0]   addr_q, data_q, word_q, crc_q;
    logic [2:0]    cnt_q;
    logic [GW-1:0] gap_q;
    logic          tx_valid, xfer, accept, is_rd, body_last, fold;
    logic [7:0]    tx_byte;

    // Modbus CRC-16: reflected polynomial 0xA001, one byte LSB first.
    function automatic logic [15:0] crc_fold(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign accept    = (state_q == IDLE) && handler_done;
    assign is_rd     = (func_code == 8'h03) || (func_code == 8'h04);
    assign xfer      = tx_valid && bus.tx_ready;
    assign body_last = (kind_q != K_ECHO) || (cnt_q == 3'd3);
    assign fold      = (state_q == HDR) || (state_q == BODY) ||
                       (state_q == DATA_HI) || (state_q == DATA_LO);

    // Classify the request into exception / read / echo frame, in priority order.
    always_comb begin
        kind_in = K_EXC;
        code_in = 8'h01;
        if (exception_code != 8'h00) begin
            code_in = exception_code;
        end else if (is_rd && (tx_quantity > MAX_Q)) begin
            code_in = 8'h03;
        end else if (is_rd) begin
            kind_in = K_READ;
        end else if (func_code == 8'h06) begin
            kind_in = K_ECHO;
        end
    end

    // Response context and the current payload word; only meaningful while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            dev_q  <= dev_addr;
            func_q <= func_code;
            addr_q <= addr;
            data_q <= data;
            n_q    <= tx_quantity;
            kind_q <= kind_in;
            code_q <= code_in;
        end
        if (state_q == RD_WAIT) begin
            word_q <= bus.dpram_rdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; every byte-sending state advances only on a transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (handler_done) state_d = HDR;
            HDR:      if (xfer && (cnt_q == 3'd1)) state_d = BODY;
            BODY: begin
                if (xfer && body_last) begin
                    if ((kind_q == K_READ) && (n_q != 8'd0)) state_d = RD_ISSUE;
                    else                                     state_d = CRC_LO;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = DATA_HI;
            DATA_HI:  if (xfer) state_d = DATA_LO;
            DATA_LO: begin
                if (xfer) begin
                    if ((word_idx_q + 8'd1) == n_q) state_d = CRC_LO;
                    else                            state_d = RD_ISSUE;
                end
            end
            CRC_LO:   if (xfer) state_d = CRC_HI;
            CRC_HI:   if (xfer) state_d = GAP;
            GAP:      if (gap_q == GAP_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Byte counters, CRC accumulation, gap timer and the status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 3'd0;
            word_idx_q <= 8'd0;
            gap_q      <= '0;
            crc_q      <= 16'hFFFF;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= (state_q == GAP) && (state_d == IDLE);
            if (handler_done && (state_q != IDLE)) overrun <= 1'b1;
            if (accept) begin
                cnt_q      <= 3'd0;
                word_idx_q <= 8'd0;
                crc_q      <= 16'hFFFF;
            end
            if (xfer) begin
                cnt_q <= (state_d == state_q) ? cnt_q + 3'd1 : 3'd0;
                if (fold) crc_q <= crc_fold(crc_q, tx_byte);
            end
            if (xfer && (state_q == DATA_LO)) word_idx_q <= word_idx_q + 8'd1;
            gap_q <= (state_q == GAP) ? gap_q + 1'b1 : '0;
        end
    end

    // Outputs decoded from state only, so tx_byte holds steady through a stall.
    always_comb begin
        tx_valid        = 1'b0;
        tx_byte         = 8'h00;
        busy            = (state_q != IDLE);
        bus.dpram_raddr = word_idx_q;
        case (state_q)
            HDR: begin
                tx_valid = 1'b1;
                if (cnt_q == 3'd0)        tx_byte = dev_q;
                else if (kind_q == K_EXC) tx_byte = func_q | 8'h80;
                else                      tx_byte = func_q;
            end
            BODY: begin
                tx_valid = 1'b1;
                case (kind_q)
                    K_READ: tx_byte = n_q << 1;
                    K_ECHO: begin
                        case (cnt_q[1:0])
                            2'd0:    tx_byte = addr_q[15:8];
                            2'd1:    tx_byte = addr_q[7:0];
                            2'd2:    tx_byte = data_q[15:8];
                            default: tx_byte = data_q[7:0];
                        endcase
                    end
                    default: tx_byte = code_q;
                endcase
            end
            DATA_HI: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[15:8];
            end
            DATA_LO: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[7:0];
            end
            CRC_LO: begin
                tx_valid = 1'b1;
                tx_byte  = crc_q[7:0];
            end
            CRC_HI: begin
                tx_valid = 1'b1;
                tx_byte  = crc_q[15:8];
            end
            default: ;
        endcase
    end

    assign bus.tx_valid = tx_valid;
    assign bus.tx_byte  = tx_byte;
endmodule

// File: tb/tb_modbus_tx_sequencer.sv
// Bench for modbus_tx_sequencer: expected frame bytes are queued when a request
// is issued and compared as the UART side accepts each byte.
module tb_modbus_tx_sequencer;
    localparam int MAX_WORDS  = 125;
    localparam int GAP_CYCLES = 1750;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  dev_addr;
    logic        handler_done;
    logic [7:0]  func_code;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  tx_quantity;
    logic [7:0]  exception_code;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    modbus_tx_sequencer_if bus();

    modbus_tx_sequencer #(
        .MAX_WORDS  (MAX_WORDS),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dev_addr       (dev_addr),
        .handler_done   (handler_done),
        .func_code      (func_code),
        .addr           (addr),
        .data           (data),
        .tx_quantity    (tx_quantity),
        .exception_code (exception_code),
        .bus            (bus),
        .busy           (busy),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [7:0]  sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          nbytes   = 0;
    int          last_xfer_edge = 0;
    int          rdy_mode = 0;
    bit          stalled  = 1'b0;
    logic [7:0]  held_byte;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    task automatic push_lit(input logic [63:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) sb.push_back(v[i*8 +: 8]);
    endtask

    // Reference frame builder straight from the Modbus RTU reply rules.
    task automatic push_frame(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                              input logic [7:0] n, input logic [7:0] ex);
        logic [7:0]  b [$];
        logic [15:0] c;
        bit          rd;
        rd = (fc == 8'h03) || (fc == 8'h04);
        b.push_back(dev_addr);
        if (ex != 8'h00) begin
            b.push_back(fc | 8'h80); b.push_back(ex);
        end else if (rd && (int'(n) > MAX_WORDS)) begin
            b.push_back(fc | 8'h80); b.push_back(8'h03);
        end else if (rd) begin
            b.push_back(fc); b.push_back(8'(2 * int'(n)));
            for (int i = 0; i < int'(n); i++) begin
                b.push_back(mem[i][15:8]); b.push_back(mem[i][7:0]);
            end
        end else if (fc == 8'h06) begin
            b.push_back(fc);
            b.push_back(a[15:8]); b.push_back(a[7:0]);
            b.push_back(d[15:8]); b.push_back(d[7:0]);
        end else begin
            b.push_back(fc | 8'h80); b.push_back(8'h01);
        end
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = crc_byte(c, b[i]);
            sb.push_back(b[i]);
        end
        sb.push_back(c[7:0]);
        sb.push_back(c[15:8]);
    endtask

    task automatic send_req(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                            input logic [7:0] n, input logic [7:0] ex);
        @(negedge clk);
        func_code = fc; addr = a; data = d; tx_quantity = n; exception_code = ex;
        handler_done = 1'b1;
        @(negedge clk);
        handler_done = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk({tag, "_frame_done"}, seen, 1);
        if (seen) begin
            chk({tag, "_gap_len"}, cyc - last_xfer_edge, GAP_CYCLES);
            chk({tag, "_busy_low"}, busy, 0);
            chk({tag, "_all_bytes"}, sb.size(), 0);
        end
    endtask

    // Clock-edge counter used to time the inter-frame gap.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read DPRAM model: data valid one cycle after the address.
    always @(posedge clk) bus.dpram_rdata <= mem[bus.dpram_raddr];

    // UART ready: always, 30% random, or held off.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ($urandom_range(0, 9) < 3);
            default: bus.tx_ready = 1'b0;
        endcase
    end

    // Byte monitor: scoreboard compare on transfer, hold check while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", bus.tx_valid, 1);
                chk("hold_byte", bus.tx_byte, held_byte);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (sb.size() == 0) chk("sb_has_entry", sb.size(), 1);
                else chk("tx_byte", bus.tx_byte, sb.pop_front());
                nbytes++;
                last_xfer_edge = cyc + 1;
                stalled = 1'b0;
            end else if (bus.tx_valid) begin
                stalled = 1'b1;
                held_byte = bus.tx_byte;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        int  base;
        bit  hit;
        rst_n = 1'b0; handler_done = 1'b0; dev_addr = 8'h01;
        func_code = 8'h00; addr = 16'h0000; data = 16'h0000;
        tx_quantity = 8'h00; exception_code = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_byte", bus.tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_raddr", bus.dpram_raddr, 0);
        rst_n = 1'b1;

        // Zero-data read, known CRC
        mem[0] = 16'h0000;
        push_lit(64'h0103_0200_00B8_44, 7);
        send_req(8'h03, 16'h0000, 16'h0001, 8'd1, 8'h00);
        chk("busy_after_req", busy, 1);
        wait_done("zero_read");

        // Handler exception
        push_lit(64'h0183_02C0_F1, 5);
        send_req(8'h03, 16'h0000, 16'h0001, 8'd1, 8'h02);
        wait_done("exc02");

        // Write single register echo
        push_lit(64'h0106_0001_0003_980B, 8);
        send_req(8'h06, 16'h0001, 16'h0003, 8'd0, 8'h00);
        wait_done("echo");

        // Func 04, four words: first with ready held high, then under backpressure
        dev_addr = 8'h11;
        push_frame(8'h04, 16'h0010, 16'h0004, 8'd4, 8'h00);
        send_req(8'h04, 16'h0010, 16'h0004, 8'd4, 8'h00);
        wait_done("rd4_ready");
        rdy_mode = 1;
        push_frame(8'h04, 16'h0010, 16'h0004, 8'd4, 8'h00);
        send_req(8'h04, 16'h0010, 16'h0004, 8'd4, 8'h00);
        wait_done("rd4_bp");
        rdy_mode = 0;
        dev_addr = 8'h01;

        // Quantity over the limit, then an unsupported function
        push_frame(8'h03, 16'h0000, 16'd126, 8'd126, 8'h00);
        send_req(8'h03, 16'h0000, 16'd126, 8'd126, 8'h00);
        wait_done("qty126");
        push_frame(8'h10, 16'h0000, 16'h0002, 8'd2, 8'h00);
        send_req(8'h10, 16'h0000, 16'h0002, 8'd2, 8'h00);
        wait_done("func10");

        // A second handler_done mid-frame must not disturb the frame in flight
        push_frame(8'h06, 16'hBEEF, 16'h1234, 8'd0, 8'h00);
        send_req(8'h06, 16'hBEEF, 16'h1234, 8'd0, 8'h00);
        repeat (2) @(negedge clk);
        send_req(8'h03, 16'h0000, 16'h0002, 8'd2, 8'h00);
        @(negedge clk);
        chk("overrun_set", overrun, 1);
        wait_done("overrun_frame");
        chk("overrun_sticky", overrun, 1);

        // Reset while the low byte of word 0 is stalled
        push_frame(8'h03, 16'h0000, 16'h0004, 8'd4, 8'h00);
        base = nbytes;
        send_req(8'h03, 16'h0000, 16'h0004, 8'd4, 8'h00);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (nbytes >= base + 4) hit = 1'b1;
        end
        chk("reach_data_lo", hit, 1);
        rdy_mode = 2;
        @(negedge clk);
        #1;
        chk("lo_stalled_valid", bus.tx_valid, 1);
        chk("lo_stalled_byte", bus.tx_byte, mem[0][7:0]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", bus.tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        push_frame(8'h03, 16'h0000, 16'h0003, 8'd3, 8'h00);
        send_req(8'h03, 16'h0000, 16'h0003, 8'd3, 8'h00);
        wait_done("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
